// File: rtl/divider_pkg.sv
// Shared types and helpers for the Newton divider front end:
// FSM state encoding, seed table depth and index extraction.
package divider_pkg;

   typedef enum logic [2:0] {
      S_LOAD,
      S_IDLE,
      S_READ,
      S_CAP,
      S_OUT
   } state_t;

   localparam int TBL_ADDR_WIDTH = 7;
   localparam int TABLE_DEPTH    = 2**TBL_ADDR_WIDTH;

   // Leading mantissa bits just below the (implicit) normalised MSB.
   function automatic logic [63:0] seed_index(
      input logic [63:0] d,
      input int          dw,
      input int          aw
   );
      return (d >> (dw - 1 - aw)) & ((64'd1 << aw) - 64'd1);
   endfunction

endpackage

// File: rtl/recip_seed_fetch.sv
// Seed table loader and lookup controller in front of the
// reciprocal seed RAM; hands estimates to the Newton stage.
module recip_seed_fetch
   import divider_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int D_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  div_valid,
   output logic                  div_ready,
   input  logic [D_WIDTH-1:0]    div_d,
   output logic                  seed_valid,
   input  logic                  seed_ready,
   output logic [DATA_WIDTH-1:0] seed_out,
   output logic [D_WIDTH-1:0]    seed_d,
   output logic                  seed_err,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   output logic                  ram_we,
   output logic                  ram_write_enable,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
      ADDR_WIDTH'(DEPTH - 1);

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [D_WIDTH-1:0]      div_q;
   logic                    loaded_q;
   logic                    seed_valid_q;
   logic [DATA_WIDTH-1:0]   seed_out_q;
   logic [D_WIDTH-1:0]      seed_d_q;
   logic                    seed_err_q;

   logic [ADDR_WIDTH-1:0]   idx_d;
   logic                    load_fire_d;
   logic                    load_done_d;
   logic                    rd_fire_d;

   assign idx_d = ADDR_WIDTH'(
      seed_index(64'(div_d), D_WIDTH, ADDR_WIDTH));

   assign load_ready  = (state_q == S_LOAD);
   assign div_ready   = (state_q == S_IDLE) && loaded_q;
   assign load_fire_d = load_ready && load_valid && !rst;
   assign load_done_d = load_last || (cnt_q == LAST_ADDR);
   assign rd_fire_d   = (state_q == S_READ) && !rst;

   // Write strobe follows the beat in the same cycle; the read
   // address register is clocked only during S_READ.
   assign ram_we           = load_fire_d;
   assign ram_write_enable = load_fire_d || rd_fire_d;
   assign ram_write_addr   = cnt_q;
   assign ram_data         = load_data;
   assign ram_read_addr    = idx_q;

   assign seed_valid = seed_valid_q;
   assign seed_out   = seed_out_q;
   assign seed_d     = seed_d_q;
   assign seed_err   = seed_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_LOAD;
         cnt_q        <= '0;
         idx_q        <= '0;
         div_q        <= '0;
         loaded_q     <= 1'b0;
         seed_valid_q <= 1'b0;
         seed_out_q   <= '0;
         seed_d_q     <= '0;
         seed_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               if (load_valid) begin
                  if (load_done_d) begin
                     cnt_q    <= '0;
                     loaded_q <= 1'b1;
                     state_q  <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_IDLE: begin
               if (div_valid && loaded_q) begin
                  div_q <= div_d;
                  idx_q <= idx_d;
                  if (!div_d[D_WIDTH-1]) begin
                     seed_err_q   <= 1'b1;
                     seed_out_q   <= '1;
                     seed_d_q     <= div_d;
                     seed_valid_q <= 1'b1;
                     state_q      <= S_OUT;
                  end else begin
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: state_q <= S_CAP;
            S_CAP: begin
               seed_out_q   <= ram_q;
               seed_d_q     <= div_q;
               seed_err_q   <= 1'b0;
               seed_valid_q <= 1'b1;
               state_q      <= S_OUT;
            end
            S_OUT: begin
               if (seed_ready) begin
                  seed_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_recip_seed_fetch.sv
// Bench for recip_seed_fetch: behavioural seed RAM, vector table
// and an expected-result queue checked on each output handshake.
module tb_recip_seed_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [7:0]  load_data;
   logic        load_last;
   logic        div_valid;
   logic        div_ready;
   logic [15:0] div_d;
   logic        seed_valid;
   logic        seed_ready;
   logic [7:0]  seed_out;
   logic [15:0] seed_d;
   logic        seed_err;
   logic [7:0]  ram_data;
   logic [6:0]  ram_write_addr;
   logic [6:0]  ram_read_addr;
   logic        ram_we;
   logic        ram_write_enable;
   logic [7:0]  ram_q;

   always #5 clk = ~clk;

   recip_seed_fetch dut (
      .clk              (clk),
      .rst              (rst),
      .load_valid       (load_valid),
      .load_ready       (load_ready),
      .load_data        (load_data),
      .load_last        (load_last),
      .div_valid        (div_valid),
      .div_ready        (div_ready),
      .div_d            (div_d),
      .seed_valid       (seed_valid),
      .seed_ready       (seed_ready),
      .seed_out         (seed_out),
      .seed_d           (seed_d),
      .seed_err         (seed_err),
      .ram_data         (ram_data),
      .ram_write_addr   (ram_write_addr),
      .ram_read_addr    (ram_read_addr),
      .ram_we           (ram_we),
      .ram_write_enable (ram_write_enable),
      .ram_q            (ram_q)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Seed RAM: global enable gates both write and read-address reg.
   logic [7:0] mem [128];
   logic [6:0] raddr_q;
   logic [6:0] exp_wa;
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         bad_wa = 0;
   assign ram_q = mem[raddr_q];

   always @(posedge clk) begin
      if (ram_write_enable && ram_we) begin
         mem[ram_write_addr] <= ram_data;
         wr_cnt++;
         if (ram_write_addr !== exp_wa) bad_wa++;
         exp_wa <= load_last ? 7'd0 : exp_wa + 7'd1;
      end else if (ram_write_enable) begin
         raddr_q <= ram_read_addr;
         rd_cnt++;
      end
      if (rst) exp_wa <= 7'd0;
   end

   typedef struct {
      logic [7:0]  seed;
      logic [15:0] d;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (!rst && seed_valid && seed_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: unexpected seed %0h", seed_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("seed_out", seed_out, e.seed);
            chk("seed_d", seed_d, e.d);
            chk("seed_err", seed_err, e.err);
         end
      end
   end

   logic [7:0] ref_tbl [128];

   task automatic load_beats(input int n, input logic [7:0] x,
                             input int last_at);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         load_valid = 1'b1;
         load_data  = 8'(i) ^ x;
         load_last  = (i == last_at);
         ref_tbl[i] = 8'(i) ^ x;
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic run_req(input logic [15:0] d, input logic [7:0] es,
                          input logic ee, input int hold);
      int lat;
      int rd0;
      logic [7:0]  so;
      logic [15:0] sd;
      @(posedge clk); #1;
      seed_ready = (hold == 0);
      div_valid  = 1'b1;
      div_d      = d;
      sb.push_back('{seed: es, d: d, err: ee});
      @(negedge clk);
      chk("req_ready", div_ready, 1);
      rd0 = rd_cnt;
      @(posedge clk); #1;
      div_valid = 1'b0;
      @(negedge clk);
      lat = 1;
      if (ee) chk("err_no_en", ram_write_enable, 0);
      else begin
         chk("rd_addr", ram_read_addr, 32'(d[14:8]));
         chk("rd_en", ram_write_enable, 1);
         chk("rd_not_wr", ram_we, 0);
      end
      while (!seed_valid && lat < 10) begin
         @(negedge clk);
         lat++;
         if (lat == 2) chk("cap_en", ram_write_enable, 0);
      end
      chk("latency", lat, ee ? 1 : 3);
      chk("rd_pulses", rd_cnt - rd0, ee ? 0 : 1);
      if (hold > 0) begin
         so = seed_out;
         sd = seed_d;
         repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", seed_valid, 1);
            chk("hold_out", seed_out, so);
            chk("hold_d", seed_d, sd);
            chk("hold_err", seed_err, ee);
            chk("hold_busy", div_ready, 0);
         end
         @(posedge clk); #1;
         seed_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_ready", div_ready, 1);
      chk("valid_drop", seed_valid, 0);
   endtask

   typedef struct {
      logic [15:0] d;
      logic [7:0]  seed;
      logic        err;
   } vec_t;
   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rd0;
      vecs[0] = '{16'hC000, 8'h15, 1'b0};
      vecs[1] = '{16'h8000, 8'h55, 1'b0};
      vecs[2] = '{16'hFFFF, 8'h2A, 1'b0};
      vecs[3] = '{16'h8100, 8'h54, 1'b0};
      vecs[4] = '{16'hAA55, 8'h7F, 1'b0};
      vecs[5] = '{16'h7FFF, 8'hFF, 1'b1};
      vecs[6] = '{16'h0000, 8'hFF, 1'b1};
      vecs[7] = '{16'h9234, 8'h47, 1'b0};

      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      div_valid  = 1'b0;
      div_d      = 16'h0;
      seed_ready = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_valid", seed_valid, 0);
         chk("rst_div_rdy", div_ready, 0);
         chk("rst_load_rdy", load_ready, 1);
         chk("rst_we", ram_we, 0);
         chk("rst_en", ram_write_enable, 0);
         chk("rst_seed", seed_out, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      load_beats(128, 8'h55, 127);
      @(negedge clk);
      chk("load_writes", wr_cnt, 128);
      chk("load_addr_seq", bad_wa, 0);
      chk("loaded_ready", div_ready, 1);
      chk("loaded_lrdy", load_ready, 0);

      // Beats offered while serving lookups must be ignored.
      load_valid = 1'b1;
      load_data  = 8'hEE;
      for (int i = 0; i < 8; i++)
         run_req(vecs[i].d, vecs[i].seed, vecs[i].err, 0);
      load_valid = 1'b0;
      chk("no_stray_wr", wr_cnt, 128);

      run_req(16'hC000, 8'h15, 1'b0, 5);
      run_req(16'h7FFF, 8'hFF, 1'b1, 3);

      @(posedge clk); #1;
      div_valid = 1'b1;
      div_d     = 16'hC000;
      @(posedge clk); #1;
      div_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("cap_rst_valid", seed_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", seed_valid, 0);
      chk("post_rst_lrdy", load_ready, 1);
      chk("post_rst_drdy", div_ready, 0);

      rd0 = rd_cnt;
      div_valid = 1'b1;
      div_d     = 16'hC000;
      repeat (3) begin
         @(negedge clk);
         chk("unloaded_drdy", div_ready, 0);
         chk("unloaded_vld", seed_valid, 0);
      end
      chk("unloaded_rd", rd_cnt - rd0, 0);
      @(posedge clk); #1;
      div_valid = 1'b0;

      load_beats(11, 8'hAA, 10);
      @(negedge clk);
      chk("part_writes", wr_cnt, 139);
      chk("part_addr_seq", bad_wa, 0);
      chk("part_ready", div_ready, 1);

      begin
         int idx [6] = '{0, 5, 10, 11, 64, 127};
         for (int i = 0; i < 6; i++)
            run_req({1'b1, 7'(idx[i]), 8'h3C}, ref_tbl[idx[i]],
                    1'b0, 0);
      end

      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
